pingpong_rd_drain: RTL and testbench

//  Read-side engine for the 2-bank ping-pong byte buffer. Waits for the writer to mark a bank full, reads
//  the bank byte-by-byte through a 1-cycle-latency read port, and emits the bytes as a valid/ready stream

---
 rtl/pingpong_rd_drain.sv | 87 ++++++++
 tb/tb_pingpong_rd_drain.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_rd_drain.sv
// pingpong_rd_drain: drains ping-pong banks 0,1,0,... into a valid/ready byte stream; PP_RD_CHKSUM_EN appends a per-bank sum byte
module pingpong_rd_drain #(
  parameter int DEPTH = 3,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bank_full,
  output logic [1:0]        bank_rel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_dat,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
);
`ifdef PP_RD_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, REL, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, REL} state_t;
`endif
  localparam logic [ADDR_W-1:0] last_idx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] base = ADDR_W'(DEPTH);
  state_t state, next;
  logic cur_bank;
  logic [ADDR_W-1:0] idx;
  logic [7:0] data;
  logic accept, at_end;
`ifdef PP_RD_CHKSUM_EN
  logic [7:0] sum;
`endif
  assign accept = m_valid && m_ready;
  assign at_end = idx == last_idx;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bank_full[cur_bank] ? ISSUE : IDLE;
      ISSUE: next = WAIT;
      WAIT: next = OUT;
`ifdef PP_RD_CHKSUM_EN
      OUT: next = !accept ? OUT : at_end ? CSUM : ISSUE;
      CSUM: next = accept ? REL : CSUM;
`else
      OUT: next = !accept ? OUT : at_end ? REL : ISSUE;
`endif
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_bank <= 1'b0;
      idx <= '0;
      data <= '0;
`ifdef PP_RD_CHKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= next;
      if (state == OUT && accept && !at_end) idx <= idx + ADDR_W'(1);
      if (state == REL) begin
        cur_bank <= ~cur_bank;
        idx <= '0;
      end
      if (state == WAIT) data <= rd_dat;
`ifdef PP_RD_CHKSUM_EN
      if (state == IDLE) sum <= '0;
      if (state == WAIT) sum <= sum + rd_dat;
      if (state == OUT && accept && at_end) data <= sum;
`endif
    end
  end
  assign rd_en = state == ISSUE;
  assign rd_addr = rd_en ? (cur_bank ? base : '0) + idx : '0;
  assign bank_rel = {state == REL && cur_bank, state == REL && !cur_bank};
  assign m_data = data;
  assign busy = state != IDLE;
`ifdef PP_RD_CHKSUM_EN
  assign m_valid = state == OUT || state == CSUM;
  assign m_last = state == CSUM;
`else
  assign m_valid = state == OUT;
  assign m_last = state == OUT && at_end;
`endif
endmodule

// File: tb/tb_pingpong_rd_drain.sv
// tb_pingpong_rd_drain: scoreboard bench with a random writer and a bank-level reference model
module tb_pingpong_rd_drain;
  localparam int DEPTH = 3;
  localparam int ADDR_W = 3;
`ifdef PP_RD_CHKSUM_EN
  localparam int BL = DEPTH + 1;
`else
  localparam int BL = DEPTH;
`endif
  localparam int NF = 24;
  logic clk = 0, rst = 1;
  logic [1:0] bank_full = 0, bank_rel;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_dat = 0;
  logic m_valid, m_last, m_ready = 0, busy;
  logic [7:0] m_data;
  logic [7:0] mem [8];
  int errors = 0, checks = 0, accepts = 0, run = 0;
  bit measure = 0;
  logic [8:0] exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [1:0] rel_q [$];
  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;

  pingpong_rd_drain #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .bank_full(bank_full), .bank_rel(bank_rel), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_dat(rd_dat), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_dat <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A full bank must come out as its bytes in order, then (optionally) their sum, then one release
  task automatic fill(input bit b, input logic [23:0] d, input bit rnd);
    logic [7:0] s, v;
    s = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = rnd ? 8'($urandom) : d[8*i +: 8];
      mem[b*DEPTH + i] = v;
      s = s + v;
      addr_q.push_back(ADDR_W'(b*DEPTH + i));
      exp_q.push_back({BL == DEPTH && i == DEPTH - 1, v});
    end
    if (BL > DEPTH) exp_q.push_back({1'b1, s});
    rel_q.push_back(b ? 2'b10 : 2'b01);
    bank_full[b] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      run = 0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", 32'(m_data), 32'(pd));
      end
      if (rd_en) begin
        check("rd_while_valid", 32'(m_valid), 0);
        check("rd_expected", 32'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        accepts++;
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("last_data", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
      end
      if (bank_rel != 0) begin
        check("rel_expected", 32'(rel_q.size() != 0), 1);
        if (rel_q.size() != 0) check("bank_rel", 32'(bank_rel), 32'(rel_q.pop_front()));
      end
      if (busy) run++;
      else begin
        if (run != 0 && measure) begin
          check("burst_len", 32'(run), 32'(3*DEPTH + 1 + BL - DEPTH));
          measure = 0;
        end
        run = 0;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  initial begin
    int fills, hold, base, c;
    bit next_fill, did_stall;
    for (int i = 0; i < 8; i++) mem[i] = 0;
    bank_full = 2'b11;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_outs", 32'({bank_rel, rd_en, rd_addr, m_valid, m_data, m_last, busy}), 0);
    end
    bank_full = 0;
    rst = 0;
    m_ready = 1;
    measure = 1;
    fill(0, 24'h332211, 0);
    fill(1, 24'hA2A1A0, 0);
    fills = 2;
    next_fill = 0;
    hold = 0;
    did_stall = 0;
    for (int cyc = 0; cyc < 5000 && (fills < NF || exp_q.size() != 0); cyc++) begin
      @(posedge clk); #1;
      for (int b = 0; b < 2; b++) if (bank_rel[b]) bank_full[b] = 1'b0;
      if (!did_stall && m_valid && accepts == 2*BL + 1) begin
        hold = 5;
        did_stall = 1;
      end
      if (hold > 0) begin
        m_ready = 0;
        hold--;
      end else m_ready = did_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (fills < NF && !bank_full[next_fill] && $urandom_range(0, 2) == 0) begin
        fill(next_fill, 24'h0120F0, fills > 2);
        fills++;
        next_fill = ~next_fill;
      end
    end
    check("drain_left", 32'(exp_q.size()), 0);
    check("fills_done", 32'(fills), NF);
    bank_full = 0;
    m_ready = 1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); addr_q.delete(); rel_q.delete();
    fill(0, 0, 1);
    base = accepts;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (accepts == base && c < 50);
    check("first_accept", 32'(accepts - base), 1);
    rst = 1;
    bank_full = 0;
    @(posedge clk); #1;
    check("midrst_outs", 32'({bank_rel, rd_en, rd_addr, m_valid, m_last, busy}), 0);
    exp_q.delete(); addr_q.delete(); rel_q.delete();
    rst = 0;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_rel_after_rst", 32'(bank_rel), 0);
    end
    fill(0, 0, 1);
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk); #1;
      if (bank_rel[0]) bank_full[0] = 1'b0;
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("restart_drained", 32'(exp_q.size() + rel_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
